dispensador_vuelto: RTL and testbench

Change-dispensing controller for the coffee machine. After a sale, the control FSM hands it the change amount in 100-colón units. The block then drives the 500 and 100 coin ejectors one coin at a time, waiting for the coin-drop sensor after each ejection. It reports progress and completion, and raises a fault if a coin jams or the sensor sticks.

---
 rtl/dispensador_vuelto.sv | 165 ++++++++++++++++
 tb/tb_dispensador_vuelto.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispensador_vuelto.sv
// dispensador_vuelto: change-dispensing controller for the coffee machine.
// Pays a change amount (100-colon units) greedily with 500 and 100 coins,
// one coin at a time, handshaking each ejection with the coin-drop sensor.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   tick     1 Hz timebase enable, one clk wide
//   start    dispense request, monto sampled on the same edge
//   monto    change amount in 100-colon units
//   ack      coin-drop sensor level, synchronous to clk
//   eject500 hold the 500 ejector open
//   eject100 hold the 100 ejector open
//   busy     high from SELECT through RELEASE
//   done     one-cycle pulse on successful completion
//   error    sticky fault flag, cleared by an accepted start or rst
//   restante change amount still to be paid
module dispensador_vuelto #(
    parameter int unsigned MAX_MONTO = 11,
    parameter int unsigned TIMEOUT   = 8,
    parameter int unsigned W         = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         start,
    input  logic [W-1:0] monto,
    input  logic         ack,
    output logic         eject500,
    output logic         eject100,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [W-1:0] restante
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_RELEASE,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [W-1:0] C_MAX     = W'(MAX_MONTO);
    localparam logic [W-1:0] C_FIVE    = W'(5);
    localparam logic [W-1:0] C_ONE     = W'(1);
    localparam logic [3:0]   C_TIMEOUT = 4'(TIMEOUT);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_coin;
    logic           w_coin_nxt;
    logic [3:0]     r_ticks;
    logic [3:0]     w_ticks_nxt;
    logic [W-1:0]   r_restante;
    logic [W-1:0]   w_restante_nxt;
    logic           r_error;
    logic           w_error_nxt;

    // Saturating increment of the handshake tick counter.
    logic [3:0]     w_ticks_inc;
    logic           w_tick_limit;

    assign w_ticks_inc  = (r_ticks == C_TIMEOUT) ? r_ticks : r_ticks + 4'd1;
    assign w_tick_limit = tick && (w_ticks_inc == C_TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_coin     <= 1'b0;
            r_ticks    <= '0;
            r_restante <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_coin     <= w_coin_nxt;
            r_ticks    <= w_ticks_nxt;
            r_restante <= w_restante_nxt;
            r_error    <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_coin_nxt     = r_coin;
        w_ticks_nxt    = r_ticks;
        w_restante_nxt = r_restante;
        w_error_nxt    = r_error;

        unique case (r_state)
            S_IDLE, S_FAULT: begin
                if (start) begin
                    w_restante_nxt = monto;
                    if (monto > C_MAX) begin
                        w_state_nxt = S_FAULT;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_SELECT;
                        w_error_nxt = 1'b0;
                    end
                end
            end

            S_SELECT: begin
                w_ticks_nxt = '0;
                if (r_restante == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    // Greedy: 500 coins first while at least 5 units remain.
                    w_coin_nxt  = (r_restante >= C_FIVE);
                    w_state_nxt = S_EJECT;
                end
            end

            S_EJECT: begin
                // ack has priority over a coinciding timeout tick.
                if (ack) begin
                    w_restante_nxt = r_restante - (r_coin ? C_FIVE : C_ONE);
                    w_ticks_nxt    = '0;
                    w_state_nxt    = S_RELEASE;
                end else if (tick) begin
                    w_ticks_nxt = w_ticks_inc;
                    if (w_tick_limit) begin
                        w_state_nxt = S_FAULT;
                        w_error_nxt = 1'b1;
                    end
                end
            end

            S_RELEASE: begin
                if (!ack) begin
                    w_ticks_nxt = '0;
                    w_state_nxt = S_SELECT;
                end else if (tick) begin
                    // Sensor stuck high: the coin never cleared.
                    w_ticks_nxt = w_ticks_inc;
                    if (w_tick_limit) begin
                        w_state_nxt = S_FAULT;
                        w_error_nxt = 1'b1;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so the async reset clears them at once.
    assign eject500 = (r_state == S_EJECT) &&  r_coin;
    assign eject100 = (r_state == S_EJECT) && !r_coin;
    assign busy     = (r_state == S_SELECT) || (r_state == S_EJECT) ||
                      (r_state == S_RELEASE);
    assign done     = (r_state == S_DONE);
    assign error    = r_error;
    assign restante = r_restante;

endmodule

// File: tb/tb_dispensador_vuelto.sv
// tb_dispensador_vuelto: directed self-checking bench for dispensador_vuelto.
// Each scenario task drives cycle-exact stimulus and compares outputs against
// hand-computed values; a negedge monitor counts coin and done pulses.
module tb_dispensador_vuelto;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         tick;
    logic         start;
    logic [W-1:0] monto;
    logic         ack;
    logic         eject500;
    logic         eject100;
    logic         busy;
    logic         done;
    logic         error;
    logic [W-1:0] restante;

    int checks = 0;
    int errors = 0;

    int n500 = 0;
    int n100 = 0;
    int ndone = 0;
    int excl_bad = 0;
    logic p500 = 1'b0;
    logic p100 = 1'b0;

    dispensador_vuelto #(
        .MAX_MONTO (11),
        .TIMEOUT   (8),
        .W         (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .monto    (monto),
        .ack      (ack),
        .eject500 (eject500),
        .eject100 (eject100),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .restante (restante)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (eject500 && !p500) n500 <= n500 + 1;
        if (eject100 && !p100) n100 <= n100 + 1;
        if (done) ndone <= ndone + 1;
        if (eject500 && eject100) excl_bad <= excl_bad + 1;
        p500 <= eject500;
        p100 <= eject100;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in EJECT; leaves it in SELECT after the coin.
    task automatic pay_coin(input logic is500, input int exp_rest);
        checks++;
        if ({eject500, eject100} !== {is500, !is500}) begin
            errors++;
            $display("FAIL pay_eject: got %b%b expected %b%b", eject500, eject100, is500, !is500);
        end
        step();
        ack = 1'b1;
        step();
        checks++;
        if ({eject500, eject100, busy} !== 3'b001 || restante !== W'(exp_rest)) begin
            errors++;
            $display("FAIL pay_release: got ej=%b%b busy=%b rest=%0d expected ej=00 busy=1 rest=%0d",
                     eject500, eject100, busy, restante, exp_rest);
        end
        ack = 1'b0;
        step();
        checks++;
        if ({eject500, eject100, busy} !== 3'b001) begin
            errors++;
            $display("FAIL pay_select: got ej=%b%b busy=%b expected ej=00 busy=1",
                     eject500, eject100, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; start = 1'b0; monto = '0; ack = 1'b0;
        step();
        step();
        checks++;
        if ({eject500, eject100, busy, done, error} !== 5'b0 || restante !== '0) begin
            errors++;
            $display("FAIL reset_state: got ej=%b%b busy=%b done=%b err=%b rest=%0d expected all 0",
                     eject500, eject100, busy, done, error, restante);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_mixed();
        int b500 = n500, b100 = n100, bd = ndone;
        start = 1'b1; monto = 8'd7;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || restante !== 8'd7 || {eject500, eject100} !== 2'b00) begin
            errors++;
            $display("FAIL mixed_select: got busy=%b rest=%0d ej=%b%b expected 1 7 00",
                     busy, restante, eject500, eject100);
        end
        step();
        pay_coin(1'b1, 2);
        step();
        pay_coin(1'b0, 1);
        step();
        pay_coin(1'b0, 0);
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || restante !== '0) begin
            errors++;
            $display("FAIL mixed_done: got done=%b busy=%b err=%b rest=%0d expected 1 0 0 0",
                     done, busy, error, restante);
        end
        step();
        checks++;
        if (done !== 1'b0 || (n500 - b500) != 1 || (n100 - b100) != 2 || (ndone - bd) != 1) begin
            errors++;
            $display("FAIL mixed_counts: got done=%b n500=%0d n100=%0d ndone=%0d expected 0 1 2 1",
                     done, n500 - b500, n100 - b100, ndone - bd);
        end
    endtask

    task automatic test_zero();
        int b500 = n500, b100 = n100;
        start = 1'b1; monto = 8'd0;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_select: got busy=%b done=%b expected 1 0", busy, done);
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b busy=%b expected 1 0", done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || (n500 - b500) != 0 || (n100 - b100) != 0) begin
            errors++;
            $display("FAIL zero_idle: got done=%b busy=%b coins=%0d expected 0 0 0",
                     done, busy, (n500 - b500) + (n100 - b100));
        end
    endtask

    task automatic test_over_limit();
        int b500 = n500, b100 = n100;
        start = 1'b1; monto = 8'd12;
        step();
        start = 1'b0;
        checks++;
        if (error !== 1'b1 || restante !== 8'd12 || busy !== 1'b0 || {eject500, eject100} !== 2'b00) begin
            errors++;
            $display("FAIL over_fault: got err=%b rest=%0d busy=%b ej=%b%b expected 1 12 0 00",
                     error, restante, busy, eject500, eject100);
        end
        step();
        checks++;
        if (error !== 1'b1 || (n500 - b500) != 0 || (n100 - b100) != 0) begin
            errors++;
            $display("FAIL over_sticky: got err=%b coins=%0d expected 1 0",
                     error, (n500 - b500) + (n100 - b100));
        end
        start = 1'b1; monto = 8'd1;
        step();
        start = 1'b0;
        checks++;
        if (error !== 1'b0 || restante !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL over_restart: got err=%b rest=%0d busy=%b expected 0 1 1",
                     error, restante, busy);
        end
        step();
        pay_coin(1'b0, 0);
        step();
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL over_done: got done=%b err=%b expected 1 0", done, error);
        end
        step();
    endtask

    task automatic test_jam();
        int bd;
        start = 1'b1; monto = 8'd5;
        step();
        start = 1'b0;
        step();
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i < 8) begin
                checks++;
                if (eject500 !== 1'b1 || error !== 1'b0) begin
                    errors++;
                    $display("FAIL jam_wait%0d: got e500=%b err=%b expected 1 0", i, eject500, error);
                end
            end else begin
                checks++;
                if (eject500 !== 1'b0 || error !== 1'b1 || restante !== 8'd5 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL jam_fault: got e500=%b err=%b rest=%0d busy=%b expected 0 1 5 0",
                             eject500, error, restante, busy);
                end
            end
            step();
        end

        // Stuck sensor: coin drops but ack never releases.
        bd = ndone;
        start = 1'b1; monto = 8'd1;
        step();
        start = 1'b0;
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL stuck_clear: got err=%b expected 0", error);
        end
        step();
        ack = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i < 8) begin
                checks++;
                if (busy !== 1'b1 || error !== 1'b0 || {eject500, eject100} !== 2'b00) begin
                    errors++;
                    $display("FAIL stuck_wait%0d: got busy=%b err=%b ej=%b%b expected 1 0 00",
                             i, busy, error, eject500, eject100);
                end
            end else begin
                checks++;
                if (error !== 1'b1 || restante !== 8'd0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL stuck_fault: got err=%b rest=%0d busy=%b expected 1 0 0",
                             error, restante, busy);
                end
            end
            step();
        end
        ack = 1'b0;
        step();
        checks++;
        if ((ndone - bd) != 0 || error !== 1'b1) begin
            errors++;
            $display("FAIL stuck_nodone: got ndone=%0d err=%b expected 0 1", ndone - bd, error);
        end
    endtask

    task automatic test_reset_mid_coin();
        start = 1'b1; monto = 8'd2;
        step();
        start = 1'b0;
        step();
        checks++;
        if (eject100 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got e100=%b expected 1", eject100);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (eject100 !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || restante !== '0) begin
            errors++;
            $display("FAIL midrst_async: got e100=%b busy=%b err=%b rest=%0d expected 0 0 0 0",
                     eject100, busy, error, restante);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || restante !== '0 || {eject500, eject100} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_idle: got busy=%b done=%b rest=%0d ej=%b%b expected 0 0 0 00",
                     busy, done, restante, eject500, eject100);
        end
    endtask

    task automatic test_ignored_start_collision();
        int b500 = n500, b100 = n100;
        start = 1'b1; monto = 8'd2;
        step();
        start = 1'b0;
        step();
        start = 1'b1; monto = 8'd3;
        step();
        start = 1'b0;
        checks++;
        if (restante !== 8'd2 || eject100 !== 1'b1) begin
            errors++;
            $display("FAIL ign_start: got rest=%0d e100=%b expected 2 1", restante, eject100);
        end
        for (int i = 1; i <= 7; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        tick = 1'b1; ack = 1'b1;
        step();
        tick = 1'b0;
        checks++;
        if (restante !== 8'd1 || error !== 1'b0 || busy !== 1'b1 || {eject500, eject100} !== 2'b00) begin
            errors++;
            $display("FAIL collision: got rest=%0d err=%b busy=%b ej=%b%b expected 1 0 1 00",
                     restante, error, busy, eject500, eject100);
        end
        ack = 1'b0;
        step();
        step();
        pay_coin(1'b0, 0);
        step();
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL ign_done: got done=%b err=%b expected 1 0", done, error);
        end
        step();
        checks++;
        if ((n100 - b100) != 2 || (n500 - b500) != 0) begin
            errors++;
            $display("FAIL ign_counts: got n100=%0d n500=%0d expected 2 0", n100 - b100, n500 - b500);
        end
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_zero();
        test_over_limit();
        test_jam();
        test_reset_mid_coin();
        test_ignored_start_collision();
        step();
        checks++;
        if (excl_bad != 0) begin
            errors++;
            $display("FAIL exclusivity: got %0d cycles with both ejects high expected 0", excl_bad);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
